mbist_march_ctrl: RTL and testbench

March C- MBIST sequencer for the single-port `fault_mem` memory under test. On `start` it walks every address 0..CAPACITY through the six March C- elements. It compares each read against the expected background and reports pass/fail on completion. It sits between the chip-level BIST request and the memory port; functional access is muxed outside this block.

---
 rtl/mbist_march_ctrl.sv | 153 +++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- MBIST sequencer; ports clk, rst_n, start -> busy/done/fail, memory port mem_write_read/mem_address/mem_wdata/mem_rdata, optional diag fail_addr/fail_exp/fail_act/fail_count (macro MBIST_DIAG_EN)
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CAPACITY   = 255,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MBIST_DIAG_EN
  ,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [15:0]           fail_count
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [2:0]            e;
    logic                  o;
    logic [ADDR_WIDTH-1:0] a;
  } op_t;
  localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  function automatic logic is_wr(op_t p);
    return p.e == 3'd0 || (p.e != 3'd5 && p.o);
  endfunction
  function automatic logic [DATA_WIDTH-1:0] bg(op_t p);
    return {DATA_WIDTH{(p.e == 3'd1 || p.e == 3'd3) ? p.o : ((p.e == 3'd2 || p.e == 3'd4) && !p.o)}};
  endfunction
  function automatic op_t nxt_op(op_t p);
    op_t n;
    logic up, two, up_n;
    up   = !(p.e == 3'd3 || p.e == 3'd4);
    two  = !(p.e == 3'd0 || p.e == 3'd5);
    up_n = !(p.e == 3'd2 || p.e == 3'd3);
    n = p;
    if (two && !p.o) n.o = 1'b1;
    else if (p.a != (up ? CAP : '0)) begin
      n.o = 1'b0;
      n.a = up ? p.a + ONE : p.a - ONE;
    end else begin
      n.e = p.e + 3'd1;
      n.o = 1'b0;
      n.a = up_n ? '0 : CAP;
    end
    return n;
  endfunction
  state_t                state;
  op_t                   cur, n1, n2, s1;
  logic                  last, mis;
  logic [7:0]            dcnt;
  logic [RD_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0] pe [RD_LATENCY];
`ifdef MBIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] pa [RD_LATENCY];
`endif
  always_comb begin
    n1   = nxt_op(cur);
    n2   = nxt_op(n1);
    s1   = nxt_op('0);
    last = cur.e == 3'd5 && cur.a == CAP;
    mis  = pv[RD_LATENCY-1] && mem_rdata != pe[RD_LATENCY-1];
  end
  // The read pipeline captures the op the memory samples at this edge;
  // its data arrives RD_LATENCY edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur            <= '0;
      dcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      pv             <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pe[i] <= '0;
`ifdef MBIST_DIAG_EN
      for (int i = 0; i < RD_LATENCY; i++) pa[i] <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      fail_count <= '0;
`endif
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
      end
      pv[0] <= state == RUN && !mem_write_read;
      pe[0] <= bg(cur);
`ifdef MBIST_DIAG_EN
      for (int i = RD_LATENCY - 1; i > 0; i--) pa[i] <= pa[i-1];
      pa[0] <= mem_address;
      if (mis) begin
        if (!fail) begin
          fail_addr <= pa[RD_LATENCY-1];
          fail_exp  <= pe[RD_LATENCY-1];
          fail_act  <= mem_rdata;
        end
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
      end
`endif
      if (mis) fail <= 1'b1;
      case (state)
        IDLE, DONE: if (start) begin
          state          <= RUN;
          busy           <= 1'b1;
          done           <= 1'b0;
          fail           <= 1'b0;
          cur            <= '0;
          mem_write_read <= 1'b1;
          mem_address    <= '0;
          pv             <= '0;
          if (is_wr(s1)) mem_wdata <= bg(s1);
`ifdef MBIST_DIAG_EN
          fail_addr  <= '0;
          fail_exp   <= '0;
          fail_act   <= '0;
          fail_count <= '0;
`endif
        end
        RUN: if (last) begin
          state          <= DRAIN;
          dcnt           <= '0;
          mem_write_read <= 1'b0;
        end else begin
          cur            <= n1;
          mem_write_read <= is_wr(n1);
          mem_address    <= n1.a;
          if (is_wr(n2)) mem_wdata <= bg(n2);
        end
        DRAIN: if (dcnt == 8'(RD_LATENCY - 1)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else dcnt <= dcnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: directed self-checking bench for mbist_march_ctrl with a 2-cycle-latency memory model
module tb_mbist_march_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       busy, done, fail, mem_write_read;
  logic [7:0] mem_address, mem_wdata, mem_rdata;
`ifdef MBIST_DIAG_EN
  logic [7:0]  fail_addr, fail_exp, fail_act;
  logic [15:0] fail_count;
`endif
  mbist_march_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MBIST_DIAG_EN
    , .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act), .fail_count(fail_count)
`endif
  );
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  logic [7:0] wd_d = 8'h00, rd1 = 8'h00, rd2 = 8'h00;
  logic       sa = 1'b0;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
  always @(posedge clk) begin
    wd_d <= mem_wdata;
    if (mem_write_read) mem[mem_address] <= wd_d;
    rd1 <= mem[mem_address] | ((sa && mem_address == 8'd5) ? 8'h08 : 8'h00);
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;
  int checks = 0, failures = 0;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [7:0] tr_a [3000];
  logic       tr_w [3000];
  logic [7:0] tr_d [3000];
  int         cyc;
  logic       d0, f0;
  logic [7:0] wd_start;
  task run(input bit mid);
    @(negedge clk);
    start = 1'b1;
    wd_start = mem_wdata;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    d0 = done;
    f0 = fail;
    while (busy && cyc < 3000) begin
      tr_a[cyc] = mem_address;
      tr_w[cyc] = mem_write_read;
      tr_d[cyc] = mem_wdata;
      cyc++;
      start = mid && cyc == 500;
      @(negedge clk);
    end
    start = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_wr", mem_write_read, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    run(0);
    chk("clean_cycles", cyc, 2562);
    chk("clean_done", done, 1);
    chk("clean_fail", fail, 0);
    chk("lead_start_wdata", wd_start, 8'h00);
    chk("m0_first_wr", tr_w[0], 1);
    chk("m0_first_addr", tr_a[0], 0);
    chk("m1_r0_wr", tr_w[256], 0);
    chk("m1_r0_lead_ff", tr_d[256], 8'hFF);
    chk("m1_w1_wr", tr_w[257], 1);
    chk("m3_start_addr", tr_a[1280], 255);
    chk("m3_start_rd", tr_w[1280], 0);
    chk("m3_end_addr", tr_a[1791], 0);
    chk("m4_start_addr", tr_a[1792], 255);
    chk("m4_start_rd", tr_w[1792], 0);
    chk("m5_last_addr", tr_a[2559], 255);
    chk("drain_idle_wr", tr_w[2560], 0);
    chk("drain_hold_addr", tr_a[2561], 255);
`ifdef MBIST_DIAG_EN
    chk("clean_count", fail_count, 0);
`endif
    sa = 1'b1;
    run(0);
    sa = 1'b0;
    chk("sa_cycles", cyc, 2562);
    chk("sa_done", done, 1);
    chk("sa_fail", fail, 1);
`ifdef MBIST_DIAG_EN
    chk("sa_addr", fail_addr, 5);
    chk("sa_exp", fail_exp, 8'h00);
    chk("sa_act", fail_act, 8'h08);
    chk("sa_count", fail_count, 3);
`endif
    run(1);
    chk("restart_done_clr", d0, 0);
    chk("restart_fail_clr", f0, 0);
    chk("restart_cycles", cyc, 2562);
    chk("restart_done", done, 1);
    chk("restart_fail", fail, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (999) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fail", fail, 0);
    chk("abort_wr", mem_write_read, 0);
    chk("abort_addr", mem_address, 0);
    chk("abort_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0);
    chk("post_rst_cycles", cyc, 2562);
    chk("post_rst_done", done, 1);
    chk("post_rst_fail", fail, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
